aes_dec_round_pipe: RTL and testbench

//  Parametrised AES decryption round with valid/ready flow control and per-beat mode select.

---
 rtl/aes_dec_round_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_aes_dec_round_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_round_pipe.sv
// AES decryption round (ARK -> IMC -> ISR -> ISB) in a STAGES-deep valid/ready pipeline.
// Optional AES_DEC_PERF_CNT_EN adds blk_cnt/stall_cnt transfer and stall counters.
module aes_dec_round_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_mode
`ifdef AES_DEC_PERF_CNT_EN
    ,
    output logic [31:0]      blk_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("aes_dec_round_pipe: STAGES must be 1..4");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse affine map followed by the GF(2^8) inverse, computed as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] r;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        r = 8'h01;
        p = b;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                  ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                  ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                  ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                  ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Stage that owns each step (0 ARK, 1 IMC, 2 ISR, 3 ISB) for the configured depth.
    function automatic int stage_of(input int step);
        case (STAGES)
            1:       return 0;
            2:       return step / 2;
            3:       return (step < 2) ? step : 2;
            default: return step;
        endcase
    endfunction

    // Mode 0 runs every step, mode 1 skips IMC, modes 2/3 stop after ARK.
    function automatic logic [127:0] round_steps(input logic [127:0] st, input logic [127:0] key,
                                                 input logic [1:0] mode, input int stage);
        logic [127:0] v;
        v = st;
        if (stage_of(0) == stage) v = v ^ key;
        if (stage_of(1) == stage && mode == 2'd0) v = inv_mix_columns(v);
        if (stage_of(2) == stage && !mode[1]) v = inv_shift_rows(v);
        if (stage_of(3) == stage && !mode[1]) v = inv_sub_bytes(v);
        return v;
    endfunction

    logic             r_valid [STAGES];
    logic [127:0]     r_state [STAGES];
    logic [1:0]       r_mode  [STAGES];
    logic [TAG_W-1:0] r_tag   [STAGES];
    logic             r_err_mode;

    logic             w_prev_valid [STAGES];
    logic [127:0]     w_prev_state [STAGES];
    logic [1:0]       w_prev_mode  [STAGES];
    logic [TAG_W-1:0] w_prev_tag   [STAGES];
    logic [127:0]     w_nxt_state  [STAGES];
    logic [STAGES:0]  w_en;
    logic             w_unused_mode;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_prev_valid[k] = in_valid;
            assign w_prev_state[k] = in_state;
            assign w_prev_mode[k]  = in_mode;
            assign w_prev_tag[k]   = in_tag;
        end else begin : g_rest
            assign w_prev_valid[k] = r_valid[k-1];
            assign w_prev_state[k] = r_state[k-1];
            assign w_prev_mode[k]  = r_mode[k-1];
            assign w_prev_tag[k]   = r_tag[k-1];
        end
        assign w_nxt_state[k] = round_steps(w_prev_state[k], in_key, w_prev_mode[k], k);
    end

    // A stage may load when it is empty or its occupant moves on this cycle.
    always_comb begin
        logic en;
        en           = out_ready;
        w_en         = '0;
        w_en[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_en[k] = !r_valid[k] || en;
            en      = w_en[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_state[k] <= '0;
                r_mode[k]  <= '0;
                r_tag[k]   <= '0;
            end
            r_err_mode <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_en[k]) begin
                    r_valid[k] <= w_prev_valid[k];
                    if (w_prev_valid[k]) begin
                        r_state[k] <= w_nxt_state[k];
                        r_mode[k]  <= w_prev_mode[k];
                        r_tag[k]   <= w_prev_tag[k];
                    end
                end
            end
            if (in_valid && w_en[0] && in_mode == 2'd3) r_err_mode <= 1'b1;
        end
    end

    assign in_ready      = w_en[0];
    assign out_valid     = r_valid[STAGES-1];
    assign out_state     = r_state[STAGES-1];
    assign out_tag       = r_tag[STAGES-1];
    assign err_mode      = r_err_mode;
    assign w_unused_mode = ^r_mode[STAGES-1];

`ifdef AES_DEC_PERF_CNT_EN
    logic [31:0] r_blk_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready)  r_blk_cnt   <= r_blk_cnt + 32'd1;
            if (out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign blk_cnt   = r_blk_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_aes_dec_round_pipe.sv
// Directed bench for aes_dec_round_pipe: vector table, back-pressure, streaming, mid-run reset.
module tb_aes_dec_round_pipe;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;
    localparam int NVEC   = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_state;
    logic [127:0]     in_key;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_state;
    logic [TAG_W-1:0] out_tag;
    logic             err_mode;
`ifdef AES_DEC_PERF_CNT_EN
    logic [31:0]      blk_cnt;
    logic [31:0]      stall_cnt;
`endif

    aes_dec_round_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_tag   (out_tag),
        .err_mode  (err_mode)
`ifdef AES_DEC_PERF_CNT_EN
        ,
        .blk_cnt   (blk_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] state;
        logic [127:0] key;
        logic [1:0]   mode;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [127:0]     q_state [$];
    logic [TAG_W-1:0] q_tag   [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_vec(input int idx, input int tag);
        in_state = vecs[idx].state;
        in_key   = vecs[idx].key;
        in_mode  = vecs[idx].mode;
        in_tag   = tag[TAG_W-1:0];
    endtask

    task automatic pop_and_check(input string name);
        if (q_state.size() == 0) begin
            check({name, "_unexpected_beat"}, 128'(out_tag), 128'hx);
        end else begin
            check({name, "_state"}, out_state, q_state.pop_front());
            check({name, "_tag"}, 128'(out_tag), 128'(q_tag.pop_front()));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int sent;
        int got;
        int inflight;
        int n_out;
        int first_out;
        int last_out;
        int stray;
        logic             prev_hold;
        logic [127:0]     prev_state;
        logic [TAG_W-1:0] prev_tag;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    2'd2, 128'h00102030405060708090a0b0c0d0e0f0};
        vecs[1] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                    2'd1, 128'hbd6e7c3df2b5779e0b61216e8b10b689};
        vecs[2] = '{128'hbd6e7c3df2b5779e0b61216e8b10b689, 128'h549932d1f08557681093ed9cbe2c974e,
                    2'd0, 128'hfde3bad205e5d0d73547964ef1fe37f1};
        vecs[3] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    2'd3, 128'h00102030405060708090a0b0c0d0e0f0};
        vecs[4] = '{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h0,
                    2'd1, 128'hbd6e7c3df2b5779e0b61216e8b10b689};
        vecs[5] = '{128'he9f74eec023020f61bf2ccf2353c21c7, 128'h0,
                    2'd0, 128'hfde3bad205e5d0d73547964ef1fe37f1};
        vecs[6] = '{128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210,
                    2'd0, 128'h52525252525252525252525252525252};
        vecs[7] = '{128'h63636363636363636363636363636363, 128'h0,
                    2'd1, 128'h0};
        vecs[8] = '{128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a,
                    2'd2, 128'hffffffffffffffffffffffffffffffff};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        check("rst_err_mode", 128'(err_mode), 128'd0);
`ifdef AES_DEC_PERF_CNT_EN
        check("rst_blk_cnt", 128'(blk_cnt), 128'd0);
        check("rst_stall_cnt", 128'(stall_cnt), 128'd0);
`endif
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // Table: one beat at a time, latency and result per vector.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive_vec(i, i);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(STAGES));
            check($sformatf("vec%0d_state", i), out_state, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), 128'(out_tag), 128'(i));
        end
        @(negedge clk);
        check("err_mode_sticky", 128'(err_mode), 128'd1);

        // Back-pressure: 8 tagged mixed-mode beats, random out_ready.
        q_state.delete();
        q_tag.delete();
        sent      = 0;
        got       = 0;
        inflight  = 0;
        prev_hold = 1'b0;
        prev_state = '0;
        prev_tag   = '0;
        for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
            @(negedge clk);
            if (prev_hold) begin
                check("bp_hold_valid", 128'(out_valid), 128'd1);
                check("bp_hold_state", out_state, prev_state);
                check("bp_hold_tag", 128'(out_tag), 128'(prev_tag));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 8) begin
                in_valid = 1'b1;
                drive_vec(sent % NVEC, sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 128'(in_ready), 128'((inflight < STAGES) || out_ready));
            if (out_valid && out_ready) begin
                pop_and_check("bp");
                got++;
                inflight--;
            end
            if (in_valid && in_ready) begin
                q_state.push_back(vecs[sent % NVEC].exp);
                q_tag.push_back(sent[TAG_W-1:0]);
                sent++;
                inflight++;
            end
            prev_hold  = out_valid && !out_ready;
            prev_state = out_state;
            prev_tag   = out_tag;
        end
        check("bp_beats_out", 128'(got), 128'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Streaming: 16 back-to-back beats, no back-pressure.
        do_reset();
        q_state.delete();
        q_tag.delete();
        sent      = 0;
        n_out     = 0;
        first_out = -1;
        last_out  = -1;
        for (int cyc = 0; cyc < 80 && n_out < 16; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 16) begin
                in_valid = 1'b1;
                drive_vec(sent % NVEC, sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                n_out++;
                pop_and_check("stream");
            end
            if (in_valid && in_ready) begin
                q_state.push_back(vecs[sent % NVEC].exp);
                q_tag.push_back(sent[TAG_W-1:0]);
                sent++;
            end
        end
        in_valid = 1'b0;
        check("stream_count", 128'(n_out), 128'd16);
        check("stream_first", 128'(first_out), 128'(STAGES));
        check("stream_span", 128'(last_out - first_out), 128'd15);
        @(negedge clk);
`ifdef AES_DEC_PERF_CNT_EN
        check("stream_blk_cnt", 128'(blk_cnt), 128'd16);
        check("stream_stall_cnt", 128'(stall_cnt), 128'd0);
`endif

        // Reset with a full pipe holding a mode-3 beat.
        do_reset();
        check("mid_err_clear", 128'(err_mode), 128'd0);
        out_ready = 1'b0;
        sent      = 0;
        for (int cyc = 0; cyc < 20 && sent < STAGES; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive_vec((3 + sent) % NVEC, sent);
            #1;
            if (in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_full_sent", 128'(sent), 128'(STAGES));
        check("mid_full_valid", 128'(out_valid), 128'd1);
        check("mid_full_in_ready", 128'(in_ready), 128'd0);
        check("mid_err_set", 128'(err_mode), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_err_mode", 128'(err_mode), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        stray = 0;
        for (int cyc = 0; cyc < 2 * STAGES + 4; cyc++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("mid_no_stale_beat", 128'(stray), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
